median_stream_ctrl: RTL and testbench
=====================================

MEDIAN_STREAM_CTRL -- requirements
Module: median_stream_ctrl

Interface
REQ-001 Parameter WORDS_PER_ROW, default 192, meaning 32-bit Avalon writes per 256-pixel RGB row.
REQ-002 Parameter ROWS, default 256, meaning source image rows per frame.
REQ-003 Parameter PRIME_ROWS, default 2, meaning rows the filter needs before its first valid output row.
REQ-004 Parameter ROW_ADDR, default 2'b00, meaning wrapper register address that receives row data.
REQ-005 Port clk  in  1  meaning the single clock; all state changes on its rising edge.
REQ-006 Port rst  in  1  meaning reset, asynchronous and active-high.
REQ-007 Port start  in  1  meaning one-cycle frame start request, honoured only in IDLE.
REQ-008 Port abort  in  1  meaning synchronous frame cancel, honoured in any state.
REQ-009 Port s_valid  in  1  meaning source pixel word valid.
REQ-010 Port s_ready  out  1  meaning controller accepts s_data this cycle.
REQ-011 Port s_data  in  32  meaning source pixel word.
REQ-012 Port av_chipselect, av_write  out  1 each  meaning Avalon master strobes to the median wrapper.
REQ-013 Port av_address  out  2  meaning Avalon address.
REQ-014 Port av_writedata  out  32  meaning Avalon write data.
REQ-015 Port av_waitrequest  in  1  meaning slave stall; tie to 0 for the current wrapper.
REQ-016 Port row_valid  out  1  meaning one-cycle pulse: filter output row is ready to capture.
REQ-017 Port row_idx  out  clog2(ROWS)  meaning output row number qualified by row_valid.
REQ-018 Port busy  out  1  meaning state is not IDLE.
REQ-019 Port frame_done  out  1  meaning one-cycle pulse after the last output row.

Function
REQ-020 The FSM SHALL have states IDLE, FEED, GAP, FLUSH, DONE.
REQ-021 IDLE -> FEED when start=1; word_cnt and row_cnt SHALL clear to 0.
REQ-022 In FEED: s_ready = !av_waitrequest; av_write = s_valid; av_writedata = s_data; av_chipselect = 1; av_address = ROW_ADDR.
REQ-023 A word is accepted when av_write=1 and av_waitrequest=0; word_cnt SHALL increment by 1 per acceptance.
REQ-024 On acceptance with word_cnt = WORDS_PER_ROW-1: word_cnt -> 0 and FEED/FLUSH -> GAP.
REQ-025 GAP SHALL last exactly one cycle with av_write=0, s_ready=0, av_chipselect=1.
REQ-026 In GAP, row_cnt SHALL increment; next state is FEED if new row_cnt < ROWS, FLUSH if < ROWS+PRIME_ROWS, else DONE.
REQ-027 In GAP, if row_cnt (pre-increment) >= PRIME_ROWS, row_valid SHALL be 1 and row_idx = row_cnt - PRIME_ROWS; otherwise row_valid = 0.
REQ-028 In FLUSH: av_write = 1, av_writedata = 0, s_ready = 0; source is not consumed.
REQ-029 DONE SHALL last one cycle with frame_done = 1, then -> IDLE.
REQ-030 A frame SHALL therefore produce exactly ROWS row_valid pulses with row_idx 0..ROWS-1 in order.
REQ-031 s_valid low in FEED SHALL stall word_cnt with av_write = 0; no timeout.
REQ-032 av_waitrequest high SHALL hold av_writedata and av_write stable and freeze counters.
REQ-033 start outside IDLE SHALL be ignored.
REQ-034 abort=1 SHALL force IDLE next cycle, clear counters, and suppress row_valid/frame_done that cycle; abort beats start.
REQ-035 Outside FEED/GAP/FLUSH, av_chipselect = av_write = 0, av_address = ROW_ADDR, av_writedata = 0.

Reset
REQ-036 While rst=1: state IDLE, counters 0, and every output low/zero except av_address = ROW_ADDR.
REQ-037 rst asserted mid-frame SHALL abandon the frame with no frame_done pulse.

Structure
REQ-038 Package median_ctrl_pkg SHALL hold the state enum and default constants (192, 256, 2, 2'b00).
REQ-039 One sub-module, median_row_counter, SHALL implement the word/row counters with wrap and terminal-count flags.

Verification
REQ-040 Defaults, s_valid held 1, waitrequest 0: start -> 258 rows of 192 writes, each followed by 1 GAP; 256 row_valid pulses, row_idx 0..255; frame_done at cycle 258*193+1 after start.
REQ-041 WORDS_PER_ROW=4, ROWS=4: s_valid deasserted for 3 cycles mid-row -> av_write low for exactly 3 cycles; word count per row still 4.
REQ-042 av_waitrequest high 2 cycles on word 2 -> av_writedata holds word 2 for 3 cycles; s_ready low for 2 cycles.
REQ-043 FLUSH rows: s_ready=0, av_writedata=0 for 2*WORDS_PER_ROW writes; no source word consumed after row 3 (ROWS=4).
REQ-044 abort on row 1 word 2 -> IDLE next cycle, busy=0, no row_valid/frame_done; a new start restarts at row 0 word 0.
REQ-045 rst pulsed mid-FEED -> all outputs return to reset values asynchronously; start ignored while in FEED.

Source files
------------

// File: rtl/median_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// median_ctrl_pkg
// Shared definitions for the median filter stream controller: the controller
// state encoding and the default geometry of one frame (256-pixel RGB rows
// packed into 192 32-bit words, 256 rows, two priming rows, row data register
// at wrapper address 0).
// -----------------------------------------------------------------------------
package median_ctrl_pkg;

    localparam int         DEF_WORDS_PER_ROW = 192;
    localparam int         DEF_ROWS          = 256;
    localparam int         DEF_PRIME_ROWS    = 2;
    localparam logic [1:0] DEF_ROW_ADDR      = 2'b00;

    typedef enum logic [2:0] {
        IDLE,   // waiting for start
        FEED,   // forwarding source words to the wrapper
        GAP,    // one idle cycle between rows, row bookkeeping
        FLUSH,  // pushing zero rows so the filter drains its last rows
        DONE    // one-cycle end-of-frame pulse
    } state_t;

endpackage

// File: rtl/median_row_counter.sv
// -----------------------------------------------------------------------------
// median_row_counter
// Word-within-row and row-within-frame counters for the median controller.
// The word counter wraps to zero after WORDS_PER_ROW accepted words; the row
// counter runs from 0 to ROWS+PRIME_ROWS. Terminal-count flags let the
// controller FSM decide the next state without doing arithmetic itself.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   clear        synchronous clear of both counters (wins over increments)
//   word_inc     one word accepted this cycle
//   row_inc      advance to the next row this cycle
//   row_cnt      current row number
//   word_last    word counter is at WORDS_PER_ROW-1
//   feed_more    row_cnt+1 is still a source row
//   flush_more   row_cnt+1 is a flush (priming drain) row
//   primed       current row has produced a valid filter output row
// -----------------------------------------------------------------------------
module median_row_counter
    import median_ctrl_pkg::*;
#(
    parameter int WORDS_PER_ROW = DEF_WORDS_PER_ROW,
    parameter int ROWS          = DEF_ROWS,
    parameter int PRIME_ROWS    = DEF_PRIME_ROWS,
    parameter int ROW_W         = $clog2(DEF_ROWS + DEF_PRIME_ROWS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             word_inc,
    input  logic             row_inc,
    output logic [ROW_W-1:0] row_cnt,
    output logic             word_last,
    output logic             feed_more,
    output logic             flush_more,
    output logic             primed
);

    localparam int WORD_W = $clog2(WORDS_PER_ROW + 1);

    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS_PER_ROW - 1);
    localparam logic [ROW_W-1:0]  FEED_END  = ROW_W'(ROWS);
    localparam logic [ROW_W-1:0]  FLUSH_END = ROW_W'(ROWS + PRIME_ROWS);
    localparam logic [ROW_W-1:0]  PRIME_CNT = ROW_W'(PRIME_ROWS);

    logic [WORD_W-1:0] word_cnt;
    logic [ROW_W-1:0]  row_next;

    assign row_next   = row_cnt + 1'b1;
    assign word_last  = (word_cnt == WORD_LAST);
    assign feed_more  = (row_next < FEED_END);
    assign flush_more = (row_next < FLUSH_END);
    assign primed     = (row_cnt >= PRIME_CNT);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
            row_cnt  <= '0;
        end else if (clear) begin
            word_cnt <= '0;
            row_cnt  <= '0;
        end else begin
            if (word_inc) begin
                word_cnt <= word_last ? '0 : word_cnt + 1'b1;
            end
            if (row_inc) begin
                row_cnt <= row_next;
            end
        end
    end

endmodule

// File: rtl/median_stream_ctrl.sv
// -----------------------------------------------------------------------------
// median_stream_ctrl
// Streams one image frame from a valid/ready pixel source into the median
// filter wrapper over Avalon-MM writes. Each source row is WORDS_PER_ROW
// writes followed by one idle GAP cycle. After the source rows, PRIME_ROWS
// rows of zeros are flushed so the filter emits its last output rows. Output
// rows are announced in the GAP cycles once the filter is primed.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start                    frame start request (IDLE only)
//   abort                    synchronous frame cancel (any state, beats start)
//   s_valid, s_ready, s_data source word handshake
//   av_chipselect, av_write,
//   av_address, av_writedata Avalon master write port to the wrapper
//   av_waitrequest           slave stall
//   row_valid, row_idx       filter output row ready, and its row number
//   busy                     controller is not IDLE
//   frame_done               one-cycle pulse after the last output row
// -----------------------------------------------------------------------------
module median_stream_ctrl
    import median_ctrl_pkg::*;
#(
    parameter int         WORDS_PER_ROW = DEF_WORDS_PER_ROW,
    parameter int         ROWS          = DEF_ROWS,
    parameter int         PRIME_ROWS    = DEF_PRIME_ROWS,
    parameter logic [1:0] ROW_ADDR      = DEF_ROW_ADDR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [31:0]             s_data,
    output logic                    av_chipselect,
    output logic                    av_write,
    output logic [1:0]              av_address,
    output logic [31:0]             av_writedata,
    input  logic                    av_waitrequest,
    output logic                    row_valid,
    output logic [$clog2(ROWS)-1:0] row_idx,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int ROW_W = $clog2(ROWS + PRIME_ROWS + 1);
    localparam int IDX_W = $clog2(ROWS);

    state_t            state;
    state_t            state_next;
    logic              cnt_clear;
    logic              word_inc;
    logic              row_inc;
    logic [ROW_W-1:0]  row_cnt;
    logic              word_last;
    logic              feed_more;
    logic              flush_more;
    logic              primed;

    median_row_counter #(
        .WORDS_PER_ROW (WORDS_PER_ROW),
        .ROWS          (ROWS),
        .PRIME_ROWS    (PRIME_ROWS),
        .ROW_W         (ROW_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (cnt_clear),
        .word_inc   (word_inc),
        .row_inc    (row_inc),
        .row_cnt    (row_cnt),
        .word_last  (word_last),
        .feed_more  (feed_more),
        .flush_more (flush_more),
        .primed     (primed)
    );

    // The wrapper only has one row-data register; the address never changes.
    assign av_address = ROW_ADDR;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        cnt_clear     = 1'b0;
        word_inc      = 1'b0;
        row_inc       = 1'b0;
        s_ready       = 1'b0;
        av_chipselect = 1'b0;
        av_write      = 1'b0;
        av_writedata  = '0;
        row_valid     = 1'b0;
        row_idx       = '0;
        frame_done    = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = FEED;
                    cnt_clear  = 1'b1;
                end
            end

            FEED: begin
                // Pass-through: a stalled slave keeps s_ready low, so the
                // source holds s_data/s_valid and the write stays stable.
                av_chipselect = 1'b1;
                s_ready       = !av_waitrequest;
                av_write      = s_valid;
                av_writedata  = s_data;
                word_inc      = s_valid && !av_waitrequest;
                if (word_inc && word_last) begin
                    state_next = GAP;
                end
            end

            GAP: begin
                av_chipselect = 1'b1;
                row_inc       = 1'b1;
                // The filter lags the input by PRIME_ROWS rows.
                if (primed) begin
                    row_valid = 1'b1;
                    row_idx   = IDX_W'(row_cnt - ROW_W'(PRIME_ROWS));
                end
                if (feed_more) begin
                    state_next = FEED;
                end else if (flush_more) begin
                    state_next = FLUSH;
                end else begin
                    state_next = DONE;
                end
            end

            FLUSH: begin
                av_chipselect = 1'b1;
                av_write      = 1'b1;
                word_inc      = !av_waitrequest;
                if (word_inc && word_last) begin
                    state_next = GAP;
                end
            end

            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Cancel overrides everything, including a start seen in IDLE.
        if (abort) begin
            state_next = IDLE;
            cnt_clear  = 1'b1;
            row_valid  = 1'b0;
            row_idx    = '0;
            frame_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_median_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_median_stream_ctrl
// Small instance (4 words/row, 4 rows, 2 priming rows, address 2'b10) for the
// directed table and corner sequences; default instance for a full frame.
// Inputs change on the falling edge, outputs are compared 1 ns later.
// -----------------------------------------------------------------------------
module tb_median_stream_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // ---------------- small instance ----------------
    logic        a_start = 1'b0, a_abort = 1'b0, a_valid = 1'b0, a_wait = 1'b0;
    logic [31:0] a_data = '0;
    logic        a_ready, a_cs, a_write, a_rv, a_busy, a_done;
    logic [1:0]  a_addr;
    logic [31:0] a_wdata;
    logic [1:0]  a_ridx;

    median_stream_ctrl #(
        .WORDS_PER_ROW (4),
        .ROWS          (4),
        .PRIME_ROWS    (2),
        .ROW_ADDR      (2'b10)
    ) dut_small (
        .clk            (clk),
        .rst            (rst),
        .start          (a_start),
        .abort          (a_abort),
        .s_valid        (a_valid),
        .s_ready        (a_ready),
        .s_data         (a_data),
        .av_chipselect  (a_cs),
        .av_write       (a_write),
        .av_address     (a_addr),
        .av_writedata   (a_wdata),
        .av_waitrequest (a_wait),
        .row_valid      (a_rv),
        .row_idx        (a_ridx),
        .busy           (a_busy),
        .frame_done     (a_done)
    );

    // ---------------- default instance ----------------
    logic        b_start = 1'b0, b_abort = 1'b0, b_valid = 1'b0, b_wait = 1'b0;
    logic [31:0] b_data = 32'h0000_0001;
    logic        b_ready, b_cs, b_write, b_rv, b_busy, b_done;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    logic [7:0]  b_ridx;

    median_stream_ctrl dut_big (
        .clk            (clk),
        .rst            (rst),
        .start          (b_start),
        .abort          (b_abort),
        .s_valid        (b_valid),
        .s_ready        (b_ready),
        .s_data         (b_data),
        .av_chipselect  (b_cs),
        .av_write       (b_write),
        .av_address     (b_addr),
        .av_writedata   (b_wdata),
        .av_waitrequest (b_wait),
        .row_valid      (b_rv),
        .row_idx        (b_ridx),
        .busy           (b_busy),
        .frame_done     (b_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        start, abort, valid, waitreq;
        logic [31:0] data;
        logic        ready, write, cs;
        logic [31:0] wdata;
        logic        rv;
        logic [1:0]  ridx;
        logic        busy, done;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    initial begin
        //            st    ab    vld   wr    data          rdy   wr    cs    wdata         rv    ridx  busy  done
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_00AA, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hD000_0000, 1'b1, 1'b1, 1'b1, 32'hD000_0000, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hD000_0001, 1'b1, 1'b1, 1'b1, 32'hD000_0001, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hD000_0002, 1'b0, 1'b1, 1'b1, 32'hD000_0002, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hD000_0002, 1'b0, 1'b1, 1'b1, 32'hD000_0002, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hD000_0002, 1'b1, 1'b1, 1'b1, 32'hD000_0002, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0055, 1'b1, 1'b0, 1'b1, 32'h0000_0055, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hD000_0003, 1'b1, 1'b1, 1'b1, 32'hD000_0003, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0099, 1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 2'd0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hE000_0000, 1'b1, 1'b1, 1'b1, 32'hE000_0000, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hE000_0001, 1'b1, 1'b1, 1'b1, 32'hE000_0001, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hE000_0002, 1'b1, 1'b1, 1'b1, 32'hE000_0002, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0077, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hF000_0000, 1'b1, 1'b1, 1'b1, 32'hF000_0000, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hF000_0001, 1'b1, 1'b1, 1'b1, 32'hF000_0001, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hF000_0002, 1'b1, 1'b1, 1'b1, 32'hF000_0002, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hF000_0003, 1'b1, 1'b1, 1'b1, 32'hF000_0003, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 2'd0, 1'b1, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0,        1'b0, 2'd0, 1'b1, 1'b0};
        vecs[21] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b0};
    end

    task automatic idle_small();
        a_start = 1'b0; a_abort = 1'b0; a_valid = 1'b0; a_wait = 1'b0; a_data = '0;
    endtask

    initial begin
        int done_k, feed_idle, feed_writes, flush_writes, flush_nonzero;
        int consumed, late_consumed, rv_cnt, gaps, writes_row;
        int b_writes, b_consumed, b_rv_cnt, b_idx_err, b_gaps, b_flush_nz;

        // ---------------- reset state ----------------
        rst = 1'b1;
        #1;
        check("rst busy", 32'(a_busy), 32'h0);
        check("rst cs", 32'(a_cs), 32'h0);
        check("rst addr", 32'(a_addr), 32'h2);
        check("rst big addr", 32'(b_addr), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // ---------------- directed table ----------------
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            a_start = vecs[i].start;
            a_abort = vecs[i].abort;
            a_valid = vecs[i].valid;
            a_wait  = vecs[i].waitreq;
            a_data  = vecs[i].data;
            #1;
            check($sformatf("v%0d s_ready", i), 32'(a_ready), 32'(vecs[i].ready));
            check($sformatf("v%0d av_write", i), 32'(a_write), 32'(vecs[i].write));
            check($sformatf("v%0d av_chipselect", i), 32'(a_cs), 32'(vecs[i].cs));
            check($sformatf("v%0d av_writedata", i), a_wdata, vecs[i].wdata);
            check($sformatf("v%0d row_valid", i), 32'(a_rv), 32'(vecs[i].rv));
            check($sformatf("v%0d row_idx", i), 32'(a_ridx), 32'(vecs[i].ridx));
            check($sformatf("v%0d busy", i), 32'(a_busy), 32'(vecs[i].busy));
            check($sformatf("v%0d frame_done", i), 32'(a_done), 32'(vecs[i].done));
        end
        @(negedge clk);
        idle_small();

        // ---------------- full small frame, 3-cycle source stall in row 1 ----------------
        @(negedge clk);
        a_start = 1'b1;
        done_k = -1; feed_idle = 0; feed_writes = 0; flush_writes = 0; flush_nonzero = 0;
        consumed = 0; late_consumed = 0; rv_cnt = 0; gaps = 0; writes_row = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            a_start = 1'b0;
            a_valid = !(k >= 7 && k <= 9);
            a_data  = 32'h1000 + 32'(k);
            #1;
            if (a_done) begin
                done_k = k;
                break;
            end
            if (a_write && !a_wait) begin
                writes_row++;
                if (a_ready) feed_writes++;
                else begin
                    flush_writes++;
                    if (a_wdata != 32'h0) flush_nonzero++;
                end
            end
            if (a_cs && a_ready && !a_write) feed_idle++;
            if (a_ready && a_valid) begin
                consumed++;
                if (gaps >= 4) late_consumed++;
            end
            if (a_cs && !a_write && !a_ready) begin
                check($sformatf("row%0d writes", gaps), 32'(writes_row), 32'd4);
                check($sformatf("gap%0d row_valid", gaps), 32'(a_rv), 32'(gaps >= 2));
                if (a_rv) begin
                    check($sformatf("gap%0d row_idx", gaps), 32'(a_ridx), 32'(rv_cnt));
                    rv_cnt++;
                end
                writes_row = 0;
                gaps++;
            end
        end
        check("frame_done cycle", 32'(done_k), 32'd33);
        check("stall write-low cycles", 32'(feed_idle), 32'd3);
        check("feed writes", 32'(feed_writes), 32'd16);
        check("flush writes", 32'(flush_writes), 32'd8);
        check("flush nonzero data", 32'(flush_nonzero), 32'd0);
        check("words consumed", 32'(consumed), 32'd16);
        check("consumed after row 3", 32'(late_consumed), 32'd0);
        check("row_valid pulses", 32'(rv_cnt), 32'd4);
        check("gap count", 32'(gaps), 32'd6);
        @(negedge clk);
        #1;
        check("post-done busy", 32'(a_busy), 32'h0);
        check("post-done frame_done", 32'(a_done), 32'h0);
        idle_small();

        // ---------------- asynchronous reset mid-FEED ----------------
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_valid = 1'b1;
        a_data  = 32'hCAFE_0001;
        @(negedge clk);
        #1;
        check("pre-rst busy", 32'(a_busy), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("async rst s_ready", 32'(a_ready), 32'h0);
        check("async rst av_write", 32'(a_write), 32'h0);
        check("async rst cs", 32'(a_cs), 32'h0);
        check("async rst writedata", a_wdata, 32'h0);
        check("async rst busy", 32'(a_busy), 32'h0);
        check("async rst addr", 32'(a_addr), 32'h2);
        @(negedge clk);
        rst = 1'b0;
        begin
            int busy_seen, done_seen;
            busy_seen = 0; done_seen = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                #1;
                if (a_busy) busy_seen++;
                if (a_done) done_seen++;
            end
            check("abandoned frame busy", 32'(busy_seen), 32'd0);
            check("abandoned frame done", 32'(done_seen), 32'd0);
        end
        idle_small();

        // ---------------- default-parameter full frame ----------------
        @(negedge clk);
        b_valid = 1'b1;
        b_start = 1'b1;
        done_k = -1; b_writes = 0; b_consumed = 0; b_rv_cnt = 0; b_idx_err = 0;
        b_gaps = 0; b_flush_nz = 0;
        for (int k = 1; k < 60000; k++) begin
            @(negedge clk);
            b_start = 1'b0;
            #1;
            if (b_done) begin
                done_k = k;
                break;
            end
            if (b_cs && b_write) begin
                b_writes++;
                if (!b_ready && b_wdata != 32'h0) b_flush_nz++;
            end
            if (b_ready && b_valid) b_consumed++;
            if (b_cs && !b_write && !b_ready) b_gaps++;
            if (b_rv) begin
                if (32'(b_ridx) != 32'(b_rv_cnt)) b_idx_err++;
                b_rv_cnt++;
            end
        end
        check("big frame_done cycle", 32'(done_k), 32'(258 * 193 + 1));
        check("big writes", 32'(b_writes), 32'(258 * 192));
        check("big consumed", 32'(b_consumed), 32'(256 * 192));
        check("big gaps", 32'(b_gaps), 32'd258);
        check("big row_valid pulses", 32'(b_rv_cnt), 32'd256);
        check("big row_idx order errors", 32'(b_idx_err), 32'd0);
        check("big flush nonzero data", 32'(b_flush_nz), 32'd0);
        @(negedge clk);
        #1;
        check("big post-done busy", 32'(b_busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
